pe_mac: RTL and testbench

PE_MAC -- requirements
Module: pe_mac

---
 rtl/pe_pkg.sv | 67 ++++++
 rtl/fp32_mul.sv | 57 +++++
 rtl/pe_mac.sv | 105 ++++++++++
 tb/tb_pe_mac.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared binary32 definitions for the PE multiply-accumulate slice.
// Provides the field widths, the bias, special-value encodings, the fp32_t
// field view, class tests (zero/inf/nan with flush-to-zero of subnormals),
// a leading-zero counter and the shared round-to-nearest-even packer.
package pe_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
  } fp32_t;

  // Subnormals have exp == 0 and are deliberately classed as zero.
  function automatic logic is_zero(input fp32_t v);
    return v.exp == 8'h00;
  endfunction

  function automatic logic is_inf(input fp32_t v);
    return (v.exp == 8'hFF) && (v.man == '0);
  endfunction

  function automatic logic is_nan(input fp32_t v);
    return (v.exp == 8'hFF) && (v.man != '0);
  endfunction

  // Number of zero bits above the leading one; 27 for an all-zero input.
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // Round {1.m} with guard/sticky to nearest-even, then saturate to Inf on
  // overflow or flush to signed zero when the biased exponent underflows.
  function automatic logic [31:0] round_pack(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [22:0] m,
                                             input logic g,
                                             input logic st);
    logic [24:0]       mr;
    logic signed [9:0] er;
    mr = {2'b01, m} + {24'd0, g & (st | m[0])};
    er = e;
    if (mr[24]) begin
      // Rounding carried out of the mantissa: value is exactly 2^(e+1).
      er = e + 10'sd1;
      mr = mr >> 1;
    end
    if (er >= 10'sd255)   return {s, 8'hFF, 23'd0};
    else if (er <= 10'sd0) return {s, 31'd0};
    else                   return {s, er[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/fp32_mul.sv
// fp32_mul: combinational binary32 multiplier.
// Full 48-bit significand product, single RNE rounding, subnormal inputs and
// results flushed to signed zero, canonical quiet NaN for NaN and Inf*0.
// Ports:
//   i_a, i_b : binary32 operands
//   o_p      : binary32 product
module fp32_mul
  import pe_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);

  fp32_t             w_a;
  fp32_t             w_b;
  logic              w_sign;
  logic [47:0]       w_prod;
  logic signed [9:0] w_exp;
  logic [22:0]       w_man;
  logic              w_g;
  logic              w_st;

  // NOTE: every combinational output gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    w_a    = i_a;
    w_b    = i_b;
    w_sign = w_a.sign ^ w_b.sign;
    w_prod = {24'd0, 1'b1, w_a.man} * {24'd0, 1'b1, w_b.man};
    w_exp  = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp}) - 10'sd127;

    // Product of two [1,2) significands lies in [1,4); normalise to [1,2).
    if (w_prod[47]) begin
      w_man = w_prod[46:24];
      w_g   = w_prod[23];
      w_st  = |w_prod[22:0];
      w_exp = w_exp + 10'sd1;
    end else begin
      w_man = w_prod[45:23];
      w_g   = w_prod[22];
      w_st  = |w_prod[21:0];
    end

    if (is_nan(w_a) || is_nan(w_b))
      o_p = QNAN;
    else if ((is_inf(w_a) && is_zero(w_b)) || (is_zero(w_a) && is_inf(w_b)))
      o_p = QNAN;
    else if (is_inf(w_a) || is_inf(w_b))
      o_p = w_sign ? NEG_INF : POS_INF;
    else if (is_zero(w_a) || is_zero(w_b))
      o_p = {w_sign, 31'd0};
    else
      o_p = round_pack(w_sign, w_exp, w_man, w_g, w_st);
  end

endmodule

// File: rtl/pe_mac.sv
// pe_mac: binary32 multiply-accumulate processing element.
// Every non-reset edge: acc <= round(acc + round(PE_a * PE_b)) (non-fused).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears acc to +0
//   PE_a : binary32 activation operand
//   PE_b : binary32 weight operand
//   PE_r : accumulator, driven straight from the register
module pe_mac
  import pe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PE_a,
  input  logic [31:0] PE_b,
  output logic [31:0] PE_r
);

  logic [31:0]       r_acc;
  logic [31:0]       w_prod;
  fp32_t             w_acc;
  fp32_t             w_p;
  fp32_t             w_x;      // larger magnitude addend
  fp32_t             w_y;      // smaller magnitude addend
  logic [7:0]        w_d;
  logic [26:0]       w_big;
  logic [49:0]       w_sh;
  logic [26:0]       w_sm;
  logic [27:0]       w_sum;
  logic [26:0]       w_diff;
  logic [4:0]        w_lz;
  logic [26:0]       w_n;
  logic signed [9:0] w_e;
  logic              w_eff_sub;
  logic [31:0]       w_next;

  fp32_mul u_mul (
    .i_a (PE_a),
    .i_b (PE_b),
    .o_p (w_prod)
  );

  always_comb begin
    w_acc = r_acc;
    w_p   = w_prod;
    if (w_p[30:0] > w_acc[30:0]) begin
      w_x = w_p;
      w_y = w_acc;
    end else begin
      w_x = w_acc;
      w_y = w_p;
    end
    w_eff_sub = w_x.sign ^ w_y.sign;
    w_d       = w_x.exp - w_y.exp;

    // Significands carry 3 extra bits below the LSB: guard, round, sticky.
    w_big = {1'b1, w_x.man, 3'b000};
    w_sh  = {1'b1, w_y.man, 26'd0} >> w_d;
    // Beyond 25 positions the smaller addend is under a quarter ULP and only
    // its existence (sticky) can influence rounding.
    if (w_d >= 8'd26) w_sm = 27'd1;
    else              w_sm = {w_sh[49:24], |w_sh[23:0]};

    w_sum  = {1'b0, w_big} + {1'b0, w_sm};
    w_diff = w_big - w_sm;
    w_lz   = clz27(w_diff);
    w_n    = w_sum[26:0];
    w_e    = $signed({2'b00, w_x.exp});

    if (w_eff_sub) begin
      w_n = w_diff << w_lz;
      w_e = w_e - $signed({5'd0, w_lz});
    end else if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = w_e + 10'sd1;
    end

    if (is_nan(w_acc) || is_nan(w_p))
      w_next = QNAN;
    else if (is_inf(w_acc) && is_inf(w_p) && (w_acc.sign != w_p.sign))
      w_next = QNAN;
    else if (is_inf(w_acc))
      w_next = r_acc;
    else if (is_inf(w_p))
      w_next = w_prod;
    else if (is_zero(w_p))
      w_next = r_acc;            // a zero product never disturbs acc
    else if (is_zero(w_acc))
      w_next = w_prod;
    else if (w_eff_sub && (w_diff == 27'd0))
      w_next = ZERO;             // exact cancellation gives +0 under RNE
    else
      w_next = round_pack(w_x.sign, w_e, w_n[25:3], w_n[2], w_n[1] | w_n[0]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_acc <= ZERO;
    else     r_acc <= w_next;
  end

  assign PE_r = r_acc;

endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: directed self-checking bench for pe_mac.
// The driver applies one operand pair per falling edge and queues the value
// PE_r must hold after the next rising edge; the monitor pops and compares
// just after each rising edge.
module tb_pe_mac;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] PE_a = 32'd0;
  logic [31:0] PE_b = 32'd0;
  logic [31:0] PE_r;

  always #5 clk = ~clk;

  pe_mac dut (
    .clk  (clk),
    .rst  (rst),
    .PE_a (PE_a),
    .PE_b (PE_b),
    .PE_r (PE_r)
  );

  logic [31:0] want_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, want);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input string tag);
    @(negedge clk);
    rst  = r;
    PE_a = a;
    PE_b = b;
    want_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  // Monitor: one registered result per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (want_q.size() > 0) begin
        string       t;
        logic [31:0] w;
        t = tag_q.pop_front();
        w = want_q.pop_front();
        check(t, PE_r, w);
      end
    end
  end

  localparam logic [31:0] EIGHT = 32'h4100_0000;
  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  initial begin
    // Reset with junk operands, then zeros must hold +0.
    step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, "reset");
    for (int i = 0; i < 5; i++)
      step(1'b0, 32'h0, 32'h0, 32'h0000_0000, "zero_hold");

    // Accumulate stream with B = 8.0.
    step(1'b0, 32'h4000_0000, EIGHT, 32'h4180_0000, "acc_16");
    step(1'b0, 32'h4080_0000, EIGHT, 32'h4240_0000, "acc_48");
    step(1'b0, 32'h4100_0000, EIGHT, 32'h42E0_0000, "acc_112");
    step(1'b0, 32'h4180_0000, EIGHT, 32'h4370_0000, "acc_240");
    step(1'b0, 32'h0,         32'h0, 32'h4370_0000, "hold_240");

    // Mid-stream reset, restart from +0, then exact cancellation to +0.
    step(1'b1, 32'h4180_0000, EIGHT,         32'h0000_0000, "mid_reset");
    step(1'b0, ONE,           32'hBF80_0000, 32'hBF80_0000, "neg_one");
    step(1'b0, ONE,           ONE,           32'h0000_0000, "cancel_pos_zero");

    // Inf * 0 gives NaN, which sticks through finite inputs.
    step(1'b0, 32'h7F80_0000, 32'h0,         QNAN, "inf_times_zero");
    step(1'b0, ONE,           ONE,           QNAN, "nan_sticky_1");
    step(1'b0, 32'h4000_0000, 32'hC000_0000, QNAN, "nan_sticky_2");

    // Overflow to +Inf, Inf absorbs finite, Inf - Inf is NaN.
    step(1'b1, 32'h0,         32'h0, 32'h0000_0000, "reset_2");
    step(1'b0, 32'h7F00_0000, ONE,   32'h7F00_0000, "acc_2pow127");
    step(1'b0, 32'h7F00_0000, ONE,   32'h7F80_0000, "overflow_inf");
    step(1'b0, 32'hC100_0000, ONE,   32'h7F80_0000, "inf_plus_finite");
    step(1'b0, 32'hFF80_0000, ONE,   QNAN,          "inf_minus_inf");

    // Multiplier rounding and flush-to-zero on inputs and results.
    step(1'b1, 32'h0,         32'h0,         32'h0000_0000, "reset_3");
    step(1'b0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "mul_rne");
    step(1'b0, 32'h0000_0001, ONE,           32'h3F80_0002, "sub_input_ftz");
    step(1'b0, 32'h0080_0000, 32'h3F00_0000, 32'h3F80_0002, "sub_result_ftz");

    // Adder ties round to even; borrow renormalises.
    step(1'b1, 32'h0,         32'h0, 32'h0000_0000, "reset_4");
    step(1'b0, ONE,           ONE,   32'h3F80_0000, "one");
    step(1'b0, 32'h3380_0000, ONE,   32'h3F80_0000, "tie_even_stays");
    step(1'b0, 32'hB380_0000, ONE,   32'h3F7F_FFFF, "sub_borrow");
    step(1'b1, 32'h0,         32'h0, 32'h0000_0000, "reset_5");
    step(1'b0, 32'h3F80_0001, ONE,   32'h3F80_0001, "odd_lsb");
    step(1'b0, 32'h3380_0000, ONE,   32'h3F80_0002, "tie_odd_up");

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && want_q.size() > 0; i++) @(negedge clk);
    if (want_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", want_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
